// File: rtl/riscv_pkg.sv
// Shared types and constants for the memory arbiter slice: FSM states,
// transaction owner encoding and the default abort timeout.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_t;

    localparam int DEFAULT_TIMEOUT = 255;

    // Width needed to hold 0..limit; a disabled (zero) limit still gets one bit.
    function automatic int timer_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Watchdog for an outstanding memory request. Counts cycles in which the
// request is pending without a ready, clears on every new grant and
// saturates at TIMEOUT. expire fires in the cycle whose edge would bring the
// count to TIMEOUT, so the arbiter can abort on that same edge. A ready in
// that cycle wins and suppresses expire. TIMEOUT = 0 disables the watchdog.
module mem_arb_timer
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic active,
    input  logic ready,
    output logic expire
);

    localparam int CW = timer_width(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic ENABLED = (TIMEOUT != 0);

    logic [CW-1:0] count;
    logic          stalled;

    assign stalled = active && !ready;

    // Saturating stall counter, restarted whenever a new transaction is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (stalled && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    // Abort request: this stalled cycle is the one that reaches the limit.
    always_comb begin
        expire = 1'b0;
        if (ENABLED && stalled && (count == (LIMIT - CW'(1)))) begin
            expire = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and data port share one
// memory interface with at most one transaction outstanding. Grants are
// combinational in IDLE, the memory request is registered, and completion
// is reported with a one-cycle rvalid pulse to the owner.
// Build option: define MEM_ARB_RR_EN to arbitrate simultaneous requests
// round-robin instead of the default fixed data-over-fetch priority.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        err_timeout
);

    arb_state_t state;
    arb_state_t next_state;
    logic       data_wins;
    logic       expire;
    logic       done;
    logic       completed;

    assign busy      = (state != IDLE);
    assign done      = busy && (mem_ready || expire);
    assign completed = busy && mem_ready;

`ifdef MEM_ARB_RR_EN
    owner_t last_owner;

    // Contention decision: the requester that lost the last contested round wins.
    always_comb begin
        data_wins = 1'b0;
        if (d_req) begin
            data_wins = !if_req || (last_owner == OWNER_IF);
        end
    end

    // Remember the winner of each contested arbitration; reset favours data first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= OWNER_IF;
        end else if ((state == IDLE) && if_req && d_req) begin
            last_owner <= data_wins ? OWNER_D : OWNER_IF;
        end
    end
`else
    // Contention decision: data always beats fetch.
    always_comb begin
        data_wins = d_req;
    end
`endif

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (if_gnt || d_gnt),
        .active (mem_req),
        .ready  (mem_ready),
        .expire (expire)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and grant logic; grants only ever appear in IDLE.
    always_comb begin
        next_state = state;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        case (state)
            IDLE: begin
                if (data_wins) begin
                    d_gnt      = 1'b1;
                    next_state = D_BUSY;
                end else if (if_req) begin
                    if_gnt     = 1'b1;
                    next_state = IF_BUSY;
                end
            end
            IF_BUSY, D_BUSY: begin
                if (mem_ready || expire) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Capture the granted payload and hold mem_req until completion or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (d_gnt) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wstrb <= d_wstrb;
        end else if (if_gnt) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_wstrb <= 4'b0000;
        end else if (done) begin
            mem_req   <= 1'b0;
        end
    end

    // One-cycle completion pulse to whichever port owned the transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
        end else begin
            if_rvalid <= done && (state == IF_BUSY);
            d_rvalid  <= done && (state == D_BUSY);
        end
    end

    // Read data capture; an aborted read returns zero, stores leave d_rdata alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else if (state == IF_BUSY) begin
            if (completed) begin
                if_rdata <= mem_rdata;
            end else if (expire) begin
                if_rdata <= '0;
            end
        end else if ((state == D_BUSY) && !mem_we) begin
            if (completed) begin
                d_rdata <= mem_rdata;
            end else if (expire) begin
                d_rdata <= '0;
            end
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout <= 1'b0;
        end else if (busy && expire) begin
            err_timeout <= 1'b1;
        end
    end

endmodule
